// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue-stage scoreboard: register index, slot request
// and writeback descriptors, plus a small two-bit population helper.
package issue_scoreboard_pkg;

  typedef logic bool;
  localparam bool true  = 1'b1;
  localparam bool false = 1'b0;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     rs_use;
    logic     rt_use;
    reg_idx_t rd;
    logic     we;
  } slot_req_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } wb_t;

  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sb_counter_cell.sv
// One register's in-flight writer counter: signed update with clamp and an
// underflow indication for the sticky error flag.
module sb_counter_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec_wb,
  input  logic [1:0]       dec_fl,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam int SW = CNT_W + 3;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << CNT_W) - 1);

  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0]     cnt_next;

  always_comb begin
    sum = $signed({3'b000, cnt})
        + $signed({{(SW-2){1'b0}}, inc})
        - $signed({{(SW-2){1'b0}}, dec_wb})
        - $signed({{(SW-2){1'b0}}, dec_fl});
    underflow = 1'b0;
    cnt_next  = sum[CNT_W-1:0];
    if (sum < 0) begin
      underflow = 1'b1;
      cnt_next  = '0;
    end else if (sum > MAXV) begin
      cnt_next  = '1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt_next;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard and in-order dual-issue grant logic. The history
// register mirrors is_ex so a flush can retire last cycle's destinations.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [1:0]      req_valid,
  input  logic [9:0]      req_rs,
  input  logic [9:0]      req_rt,
  input  logic [1:0]      req_rs_use,
  input  logic [1:0]      req_rt_use,
  input  logic [9:0]      req_rd,
  input  logic [1:0]      req_we,
  input  logic [1:0]      wb_valid,
  input  logic [9:0]      wb_rd,
  output logic [1:0]      grant_num,
  output logic            stall_from_issue,
  output logic [NREG-1:0] busy_o,
  output logic            err_o
);

  slot_req_t        req [2];
  wb_t              wb  [2];
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:1]  uf;
  logic [1:0]       wr, src_ok, dst_ok, g;
  bool              raw, waw;
  logic [1:0]       hist_v;
  reg_idx_t         hist_rd [2];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      req[i] = '{valid: req_valid[i], rs: req_rs[5*i +: 5], rt: req_rt[5*i +: 5],
                 rs_use: req_rs_use[i], rt_use: req_rt_use[i],
                 rd: req_rd[5*i +: 5], we: req_we[i]};
      wb[i]  = '{valid: wb_valid[i], rd: wb_rd[5*i +: 5]};
    end
  end

  assign cnt[0] = '0;

  // Readiness uses registered counts only: a writeback unblocks next cycle.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      wr[i]     = req[i].we && (req[i].rd != '0);
      src_ok[i] = (!req[i].rs_use || req[i].rs == '0 || cnt[req[i].rs] == '0) &&
                  (!req[i].rt_use || req[i].rt == '0 || cnt[req[i].rt] == '0);
      dst_ok[i] = !wr[i] || (cnt[req[i].rd] != '1);
    end
    raw  = wr[0] && ((req[1].rs_use && req[1].rs == req[0].rd) ||
                     (req[1].rt_use && req[1].rt == req[0].rd));
    waw  = wr[0] && wr[1] && (req[1].rd == req[0].rd);
    g[0] = !stall_i && !flush_i && req[0].valid && src_ok[0] && dst_ok[0];
    g[1] = g[0] && req[1].valid && src_ok[1] && dst_ok[1] && !raw && !waw;
  end

  assign grant_num        = count2(g[0], g[1]);
  assign stall_from_issue = req[0].valid && (grant_num == 2'd0) && !stall_i && !flush_i;
  assign busy_o[0]        = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cell
    logic [1:0] inc, dec_wb, dec_fl;

    assign inc    = count2(g[0] && wr[0] && req[0].rd == reg_idx_t'(r),
                           g[1] && wr[1] && req[1].rd == reg_idx_t'(r));
    assign dec_wb = count2(wb[0].valid && wb[0].rd == reg_idx_t'(r),
                           wb[1].valid && wb[1].rd == reg_idx_t'(r));
    assign dec_fl = count2(flush_i && hist_v[0] && hist_rd[0] == reg_idx_t'(r),
                           flush_i && hist_v[1] && hist_rd[1] == reg_idx_t'(r));

    sb_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk       (clk),
      .resetn    (resetn),
      .inc       (inc),
      .dec_wb    (dec_wb),
      .dec_fl    (dec_fl),
      .cnt       (cnt[r]),
      .underflow (uf[r])
    );

    assign busy_o[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_v     <= '0;
      hist_rd[0] <= '0;
      hist_rd[1] <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= err_o | (|uf);
      if (flush_i) begin
        hist_v <= '0;
      end else if (!stall_i) begin
        for (int unsigned i = 0; i < 2; i++) begin
          hist_v[i]  <= g[i] & wr[i];
          hist_rd[i] <= req[i].rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: expected {stall_from_issue, grant_num} pushed when each
// cycle's stimulus is driven and popped at the following negedge.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_i, flush_i;
  logic [1:0]  req_valid, req_rs_use, req_rt_use, req_we, wb_valid;
  logic [9:0]  req_rs, req_rt, req_rd, wb_rd;
  logic [1:0]  grant_num;
  logic        stall_from_issue;
  logic [31:0] busy_o;
  logic        err_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [2:0]  exp_q [$];
  logic [2:0]  e;

  always #5 clk = ~clk;

  issue_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .stall_i(stall_i), .flush_i(flush_i),
    .req_valid(req_valid), .req_rs(req_rs), .req_rt(req_rt),
    .req_rs_use(req_rs_use), .req_rt_use(req_rt_use), .req_rd(req_rd),
    .req_we(req_we), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .grant_num(grant_num), .stall_from_issue(stall_from_issue),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic clear_inputs();
    stall_i = 0; flush_i = 0; req_valid = '0; req_rs = '0; req_rt = '0;
    req_rs_use = '0; req_rt_use = '0; req_rd = '0; req_we = '0;
    wb_valid = '0; wb_rd = '0;
  endtask

  task automatic set_slot(input int i, input logic [4:0] rd, input logic we,
                          input logic [4:0] rs, input logic rs_use,
                          input logic [4:0] rt, input logic rt_use);
    req_valid[i] = 1'b1; req_we[i] = we; req_rd[5*i +: 5] = rd;
    req_rs[5*i +: 5] = rs; req_rs_use[i] = rs_use;
    req_rt[5*i +: 5] = rt; req_rt_use[i] = rt_use;
  endtask

  task automatic set_wb(input int i, input logic [4:0] rd);
    wb_valid[i] = 1'b1; wb_rd[5*i +: 5] = rd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs(); set_slot(0, 5'd5, 1, 5'd1, 1, 5'd2, 1);
    exp_q.push_back(3'b001); exp_q.push_back(3'b001);
    repeat (2) begin
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if ({stall_from_issue, grant_num} !== e) begin
        failures++; $display("FAIL reset_prep_r5 got=%b exp=%b", {stall_from_issue, grant_num}, e);
      end
      tick();
    end
    clear_inputs(); set_slot(0, 5'd12, 1, 5'd0, 0, 5'd0, 0); set_slot(1, 5'd13, 1, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(3'b010);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL reset_prep_pair got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0000_3020) begin
      failures++; $display("FAIL reset_prep_busy got=%h exp=%h", busy_o, 32'h0000_3020);
    end
    #2 resetn = 0;
    #1 checks++;
    if (busy_o !== 32'h0 || grant_num !== 2'd0) begin
      failures++; $display("FAIL async_reset busy=%h grant=%0d exp busy=0 grant=0", busy_o, grant_num);
    end
    #1 resetn = 1;
    // A flush right after reset must not decrement anything if hist was cleared.
    flush_i = 1;
    tick(); clear_inputs();
    checks++;
    if (err_o !== 1'b0 || busy_o !== 32'h0) begin
      failures++; $display("FAIL reset_hist_clear err=%b busy=%h exp err=0 busy=0", err_o, busy_o);
    end
  endtask

  task automatic test_independent();
    clear_inputs();
    set_slot(0, 5'd3, 1, 5'd1, 1, 5'd2, 1); set_slot(1, 5'd4, 1, 5'd5, 1, 5'd6, 1);
    exp_q.push_back(3'b010);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL pair_grant got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0000_0018) begin
      failures++; $display("FAIL pair_busy got=%h exp=%h", busy_o, 32'h18);
    end
    set_wb(0, 5'd3); set_wb(1, 5'd4);
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0) begin
      failures++; $display("FAIL pair_wb_clear got=%h exp=0", busy_o);
    end
  endtask

  task automatic test_raw();
    logic [2:0] seq [4] = '{3'b001, 3'b100, 3'b100, 3'b001};
    clear_inputs();
    foreach (seq[k]) begin
      clear_inputs();
      if (k == 0) begin
        set_slot(0, 5'd7, 1, 5'd1, 1, 5'd2, 1); set_slot(1, 5'd8, 1, 5'd7, 1, 5'd0, 0);
      end else begin
        set_slot(0, 5'd8, 1, 5'd7, 1, 5'd0, 0);
      end
      if (k == 2) set_wb(0, 5'd7);
      exp_q.push_back(seq[k]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if ({stall_from_issue, grant_num} !== e) begin
        failures++; $display("FAIL raw_step%0d got=%b exp=%b", k, {stall_from_issue, grant_num}, e);
      end
      tick();
    end
    clear_inputs(); set_wb(1, 5'd8);
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0) begin
      failures++; $display("FAIL raw_cleanup got=%h exp=0", busy_o);
    end
  endtask

  task automatic test_flush();
    clear_inputs(); set_slot(0, 5'd8, 1, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(3'b001);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL flush_issue got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick();
    clear_inputs(); flush_i = 1; set_slot(0, 5'd9, 1, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(3'b000);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL flush_cycle got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL flush_retire busy=%h err=%b exp busy=0 err=0", busy_o, err_o);
    end
  endtask

  task automatic test_stall_hold();
    clear_inputs(); set_slot(0, 5'd9, 1, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(3'b001);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL stall_issue got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      clear_inputs(); stall_i = 1; set_slot(0, 5'd20, 1, 5'd0, 0, 5'd0, 0);
      if (c == 3) flush_i = 1;
      exp_q.push_back(3'b000);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if ({stall_from_issue, grant_num} !== e || busy_o !== 32'h0000_0200) begin
        failures++; $display("FAIL stall_cycle%0d got=%b busy=%h exp=%b busy=%h",
                             c, {stall_from_issue, grant_num}, busy_o, e, 32'h200);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (busy_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL stall_flush_retire busy=%h err=%b exp busy=0 err=0", busy_o, err_o);
    end
  endtask

  task automatic test_waw_r0();
    clear_inputs(); set_slot(0, 5'd14, 1, 5'd0, 0, 5'd0, 0); set_slot(1, 5'd14, 1, 5'd0, 0, 5'd0, 0);
    exp_q.push_back(3'b001);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL waw_block got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick();
    clear_inputs(); set_slot(0, 5'd0, 1, 5'd0, 1, 5'd0, 1); set_slot(1, 5'd0, 1, 5'd0, 1, 5'd0, 1);
    set_wb(0, 5'd14);
    exp_q.push_back(3'b010);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if ({stall_from_issue, grant_num} !== e) begin
      failures++; $display("FAIL r0_pair got=%b exp=%b", {stall_from_issue, grant_num}, e);
    end
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL r0_no_busy busy=%h err=%b exp busy=0 err=0", busy_o, err_o);
    end
  endtask

  task automatic test_saturation_underflow();
    logic [2:0] seq [4] = '{3'b001, 3'b001, 3'b001, 3'b100};
    foreach (seq[k]) begin
      clear_inputs(); set_slot(0, 5'd10, 1, 5'd0, 0, 5'd0, 0);
      exp_q.push_back(seq[k]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if ({stall_from_issue, grant_num} !== e) begin
        failures++; $display("FAIL sat_write%0d got=%b exp=%b", k, {stall_from_issue, grant_num}, e);
      end
      tick();
    end
    clear_inputs(); set_wb(0, 5'd10); set_wb(1, 5'd10);
    tick();
    clear_inputs(); set_wb(0, 5'd10);
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL sat_drain busy=%h err=%b exp busy=0 err=0", busy_o, err_o);
    end
    set_wb(1, 5'd11);
    tick(); clear_inputs();
    checks++;
    if (busy_o !== 32'h0 || err_o !== 1'b1) begin
      failures++; $display("FAIL underflow busy=%h err=%b exp busy=0 err=1", busy_o, err_o);
    end
    repeat (3) tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err_o);
    end
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    test_reset();
    test_independent();
    test_raw();
    test_flush();
    test_stall_hold();
    test_waw_r0();
    test_saturation_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
